// File: rtl/cb_bit_sequencer.sv
// Sequencer driving the ALU line bundle through BS -> OP -> RES for CB BIT/RES/SET b,r.
// Optional macro CB_SEQ_BACK2BACK_EN: accept the next request in the cycle the response is taken.
module cb_bit_sequencer #(
    parameter logic [1:0] IDLE_OE = 2'b00  // NO_OE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] cb_op,
    input  logic [7:0] operand,
    output logic [2:0] alu_bs,
    output logic [7:0] alu_op,
    output logic [1:0] alu_sh,
    output logic [1:0] alu_oe,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       done_valid,
    input  logic       done_ready,
    output logic [7:0] res,
    output logic       wb,
    output logic       flag_we,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_h,
    output logic       illegal
);

    localparam logic [1:0] BS_OE  = 2'b01;
    localparam logic [1:0] SH_OE  = 2'b10;
    localparam logic [1:0] RES_OE = 2'b11;
    localparam logic       BUS_LD = 1'b1;
    localparam logic       NO_LD  = 1'b0;
    localparam logic [1:0] NO_SH  = 2'b00;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BS   = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_RES  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [1:0] r_group;
    logic [2:0] r_bit;
    logic [7:0] r_operand;
    logic [7:0] r_res;
    logic       r_wb;
    logic       r_flag_we;
    logic       r_flag_z;
    logic       r_flag_n;
    logic       r_flag_h;
    logic       r_illegal;

    logic w_accept;
    logic w_done_fire;
    logic w_illegal_req;
    logic w_is_bit;
    logic w_is_res;
    logic w_is_set;
    logic w_unused;

`ifdef CB_SEQ_BACK2BACK_EN
    assign start_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && done_ready);
`else
    assign start_ready = (r_state == S_IDLE);
`endif

    assign done_valid    = (r_state == S_DONE);
    assign w_accept      = start_valid && start_ready;
    assign w_done_fire   = done_valid && done_ready;
    assign w_illegal_req = (cb_op[7:6] == 2'b00);
    assign w_is_bit      = (r_group == 2'b01);
    assign w_is_res      = (r_group == 2'b10);
    assign w_is_set      = (r_group == 2'b11);
    assign w_unused      = ^{cb_op[2:0], alu_carry};

    assign res     = r_res;
    assign wb      = r_wb;
    assign flag_we = r_flag_we;
    assign flag_z  = r_flag_z;
    assign flag_n  = r_flag_n;
    assign flag_h  = r_flag_h;
    assign illegal = r_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_illegal_req ? S_DONE : S_BS;
            S_BS:   w_state_nxt = S_OP;
            S_OP:   w_state_nxt = S_RES;
            S_RES:  w_state_nxt = S_DONE;
            S_DONE: begin
                // An accept here can only happen in back-to-back builds.
                if (w_done_fire) begin
                    if (w_accept) w_state_nxt = w_illegal_req ? S_DONE : S_BS;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_group   <= '0;
            r_bit     <= '0;
            r_operand <= '0;
            r_res     <= '0;
            r_wb      <= 1'b0;
            r_flag_we <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
            r_flag_h  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_group   <= cb_op[7:6];
                r_bit     <= cb_op[5:3];
                r_operand <= operand;
                if (w_illegal_req) begin
                    r_res     <= operand;
                    r_wb      <= 1'b0;
                    r_flag_we <= 1'b0;
                    r_flag_z  <= 1'b0;
                    r_flag_n  <= 1'b0;
                    r_flag_h  <= 1'b0;
                    r_illegal <= 1'b1;
                end
            end else if (r_state == S_RES) begin
                r_illegal <= 1'b0;
                if (w_is_bit) begin
                    r_res     <= r_operand;
                    r_wb      <= 1'b0;
                    r_flag_we <= 1'b1;
                    r_flag_z  <= alu_zero;
                    r_flag_n  <= 1'b0;
                    r_flag_h  <= 1'b1;
                end else begin
                    r_res     <= alu_result;
                    r_wb      <= 1'b1;
                    r_flag_we <= 1'b0;
                    r_flag_z  <= 1'b0;
                    r_flag_n  <= 1'b0;
                    r_flag_h  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        alu_la = NO_LD;
        alu_lb = NO_LD;
        alu_oe = IDLE_OE;
        alu_sh = NO_SH;
        alu_bs = '0;
        alu_op = '0;
        alu_r  = 1'b0;
        alu_s  = 1'b0;
        alu_v  = 1'b0;
        alu_ne = 1'b0;
        alu_ci = 1'b0;
        alu_l  = 1'b0;
        alu_h  = 1'b0;
        case (r_state)
            S_BS: begin
                alu_bs = r_bit;
                alu_oe = BS_OE;
                alu_lb = BUS_LD;
            end
            S_OP: begin
                alu_op = r_operand;
                alu_oe = SH_OE;
                alu_la = BUS_LD;
                alu_s  = 1'b1;
                alu_ci = 1'b1;
                alu_l  = 1'b1;
                alu_r  = w_is_set;
                alu_ne = w_is_res;
            end
            S_RES: begin
                alu_oe = RES_OE;
                alu_s  = 1'b1;
                alu_ci = 1'b1;
                alu_h  = 1'b1;
                alu_r  = w_is_set;
                alu_ne = w_is_res;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    // The ALU holds carry high for the whole mask operation; a low carry is a wiring/protocol fault.
    a_carry_high: assert property (@(posedge clk) disable iff (reset)
        ((r_state == S_OP) || (r_state == S_RES)) |-> alu_carry);
`endif

endmodule

// File: tb/tb_cb_bit_sequencer.sv
// Directed bench for cb_bit_sequencer with a behavioural ALU and a response scoreboard.
module tb_cb_bit_sequencer;

    localparam logic [1:0] NO_OE  = 2'b00;
    localparam logic [1:0] BS_OE  = 2'b01;
    localparam logic [1:0] SH_OE  = 2'b10;
    localparam logic [1:0] RES_OE = 2'b11;
    localparam logic       BUS_LD = 1'b1;
    localparam logic       NO_LD  = 1'b0;
    localparam logic [1:0] NO_SH  = 2'b00;

    logic       clk, reset;
    logic       start_valid, start_ready;
    logic [7:0] cb_op, operand;
    logic [2:0] alu_bs;
    logic [7:0] alu_op;
    logic [1:0] alu_sh, alu_oe;
    logic       alu_la, alu_lb, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry;
    logic       done_valid, done_ready;
    logic [7:0] res;
    logic       wb, flag_we, flag_z, flag_n, flag_h, illegal;

    cb_bit_sequencer #(.IDLE_OE(NO_OE)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .cb_op(cb_op), .operand(operand),
        .alu_bs(alu_bs), .alu_op(alu_op), .alu_sh(alu_sh), .alu_oe(alu_oe),
        .alu_la(alu_la), .alu_lb(alu_lb),
        .alu_r(alu_r), .alu_s(alu_s), .alu_v(alu_v), .alu_ne(alu_ne),
        .alu_ci(alu_ci), .alu_l(alu_l), .alu_h(alu_h),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .done_valid(done_valid), .done_ready(done_ready),
        .res(res), .wb(wb), .flag_we(flag_we),
        .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: B latch takes the one-hot mask, A latch takes the operand.
    logic [7:0] m_mask, m_a;
    always @(posedge clk) begin
        if (alu_lb == BUS_LD && alu_oe == BS_OE) m_mask <= 8'd1 << alu_bs;
        if (alu_la == BUS_LD) m_a <= alu_op;
    end
    assign alu_result = alu_r ? (m_a | m_mask) : (alu_ne ? (m_a & ~m_mask) : (m_a & m_mask));
    assign alu_zero   = (alu_result == 8'd0);
    assign alu_carry  = 1'b1;

    typedef struct packed {
        logic [7:0] res;
        logic wb, fwe, z, n, h, ill;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [23:0] w_alu;
    assign w_alu = {alu_la, alu_lb, alu_oe, alu_sh, alu_bs, alu_op,
                    alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h};
    localparam logic [23:0] IDLE_LINES = {NO_LD, NO_LD, NO_OE, NO_SH, 3'd0, 8'd0, 7'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] cb, input logic [7:0] op);
        exp_t       e;
        logic [7:0] m;
        m = 8'd1 << cb[5:3];
        e = '0;
        case (cb[7:6])
            2'b00: begin e.res = op; e.ill = 1'b1; end
            2'b01: begin e.res = op; e.fwe = 1'b1; e.z = ((op & m) == 8'd0); e.h = 1'b1; end
            2'b10: begin e.res = op & ~m; e.wb = 1'b1; end
            default: begin e.res = op | m; e.wb = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb"}, sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_res"}, res, e.res);
        chk({tag, "_wb"}, wb, e.wb);
        chk({tag, "_fwe"}, flag_we, e.fwe);
        chk({tag, "_ill"}, illegal, e.ill);
        if (e.fwe) chk({tag, "_znh"}, {flag_z, flag_n, flag_h}, {e.z, e.n, e.h});
    endtask

    // One request through to its response; hold = cycles of done_ready=0, noise = busy-time junk.
    task automatic run_op(input string tag, input logic [7:0] cb, input logic [7:0] op,
                          input int hold, input bit noise);
        logic        r_f, ne_f;
        int unsigned lat;
        r_f  = (cb[7:6] == 2'b11);
        ne_f = (cb[7:6] == 2'b10);
        start_valid = 1'b1; cb_op = cb; operand = op;
        sb_q.push_back(model(cb, op));
        chk({tag, "_rdy"}, start_ready, 1);
        tick();
        if (noise) begin cb_op = ~cb; operand = ~op; end
        else start_valid = 1'b0;
        lat = 1;
        if (cb[7:6] != 2'b00) begin
            chk({tag, "_bs"}, w_alu, {NO_LD, BUS_LD, BS_OE, NO_SH, cb[5:3], 8'd0, 7'd0});
            chk({tag, "_busy"}, start_ready, 0);
            tick();
            chk({tag, "_op"}, w_alu, {BUS_LD, NO_LD, SH_OE, NO_SH, 3'd0, op,
                                      r_f, 1'b1, 1'b0, ne_f, 1'b1, 1'b1, 1'b0});
            tick();
            chk({tag, "_resph"}, w_alu, {NO_LD, NO_LD, RES_OE, NO_SH, 3'd0, 8'd0,
                                         r_f, 1'b1, 1'b0, ne_f, 1'b1, 1'b0, 1'b1});
            chk({tag, "_early"}, done_valid, 0);
            tick();
            lat = 4;
        end else begin
            chk({tag, "_idle"}, w_alu, IDLE_LINES);
        end
        while (!done_valid && lat < 12) begin tick(); lat++; end
        chk({tag, "_lat"}, lat, (cb[7:6] == 2'b00) ? 1 : 4);
        start_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_holdv"}, done_valid, 1);
            if (sb_q.size() != 0) chk({tag, "_holdr"}, res, sb_q[0].res);
        end
        done_ready = 1'b1;
        check_resp(tag);
        tick();
        done_ready = 1'b0;
        chk({tag, "_dv0"}, done_valid, 0);
        chk({tag, "_rdy1"}, start_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_valid = 1'b0; cb_op = '0; operand = '0; done_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_rdy", start_ready, 1);
        chk("rst_dv", done_valid, 0);
        chk("rst_out", {res, wb, flag_we, flag_z, flag_n, flag_h, illegal}, 14'd0);
        chk("rst_alu", w_alu, IDLE_LINES);

        run_op("bit3",  8'h5E, 8'h08, 0, 1'b0);
        run_op("bit7",  8'h7E, 8'h7F, 0, 1'b0);
        run_op("res0",  8'h87, 8'hFF, 0, 1'b0);
        run_op("set4",  8'hE0, 8'h00, 0, 1'b0);
        run_op("ill",   8'h12, 8'h5A, 0, 1'b0);
        run_op("hold",  8'h50, 8'h04, 3, 1'b1);
        run_op("illh",  8'h07, 8'hC3, 2, 1'b0);

        // Reset while the OP phase is on the lines.
        start_valid = 1'b1; cb_op = 8'hD0; operand = 8'h01;
        tick();
        start_valid = 1'b0;
        tick();
        chk("rst_inop", alu_la, BUS_LD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_dv", done_valid, 0);
        chk("abort_rdy", start_ready, 1);
        chk("abort_alu", w_alu, IDLE_LINES);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_quiet", done_valid, 0);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] rc, ro;
            rc = 8'($urandom_range(8'h40, 8'hFF));
            ro = 8'($urandom);
            run_op("rnd", rc, ro, int'($urandom_range(0, 2)), 1'b0);
        end

`ifdef CB_SEQ_BACK2BACK_EN
        start_valid = 1'b1; cb_op = 8'hC8; operand = 8'h00;
        sb_q.push_back(model(8'hC8, 8'h00));
        tick();
        start_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b_dv1", done_valid, 1);
        done_ready = 1'b1; start_valid = 1'b1; cb_op = 8'h88; operand = 8'hFF;
        chk("b2b_rdy", start_ready, 1);
        check_resp("b2b1");
        sb_q.push_back(model(8'h88, 8'hFF));
        tick();
        start_valid = 1'b0; done_ready = 1'b0;
        chk("b2b_bs", {alu_lb, alu_bs}, {BUS_LD, 3'd1});
        tick(); tick(); tick();
        chk("b2b_dv2", done_valid, 1);
        done_ready = 1'b1;
        check_resp("b2b2");
        tick();
        done_ready = 1'b0;
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
